// File: rtl/laser_pkg.sv
// Shared types and helpers for the multi-channel laser link receiver.
package laser_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Three-sample window centred on the bit middle: sc in {M-1, M, M+1}.
  function automatic logic vote_window(input int unsigned sc, input int unsigned oversample);
    return (sc + 1 >= oversample / 2) && (sc <= oversample / 2 + 1);
  endfunction

endpackage

// File: rtl/laser_rx_channel.sv
// One laser lane: synchroniser, majority-vote frame recovery and a
// single-entry holding register drained by the array alignment stage.
module laser_rx_channel
  import laser_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 laser_i,
  input  logic                 take_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 full_o,
  output logic                 frame_error_o,
  output logic                 overrun_o
);

  localparam int SC_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [SYNC_DEPTH-1:0] sync_q;
  rx_state_t             state_q, state_d;
  logic [SC_W-1:0]       sc_q;
  logic [BC_W-1:0]       bit_q;
  logic [1:0]            votes_q, votes_now;
  logic [DATA_BITS-1:0]  shift_q, hold_q;
  logic                  full_q, frame_error_q, overrun_q;
  logic                  s, in_win, decide, bit_val, last_bit;
  logic                  shift_en, stop_good, stop_bad, write;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_DEPTH-2:0], laser_i};
  end

  assign s         = sync_q[SYNC_DEPTH-1];
  assign in_win    = vote_window(32'(sc_q), OVERSAMPLE);
  assign votes_now = votes_q + {1'b0, in_win & s};
  assign bit_val   = votes_now >= 2'd2;
  assign decide    = enable_i && (state_q != IDLE) && (sc_q == SC_W'(OVERSAMPLE - 1));
  assign last_bit  = bit_q == BC_W'(DATA_BITS - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (!s)                 state_d = START;
        START: if (decide)             state_d = bit_val ? IDLE : DATA;
        DATA:  if (decide && last_bit) state_d = STOP;
        STOP:  if (decide)             state_d = IDLE;
        default:                       state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (decide) begin
      shift_en  = state_q == DATA;
      stop_good = (state_q == STOP) && bit_val;
      stop_bad  = (state_q == STOP) && !bit_val;
    end
  end

  // A take in the same cycle vacates the slot, so the new byte is accepted.
  assign write = stop_good && (!full_q || take_i);

  // NOTE: the shift and holding registers are reset as well so data_out never
  // carries X after reset; they are only a few flops per lane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_q          <= '0;
      bit_q         <= '0;
      votes_q       <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      full_q        <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (!enable_i || state_q == IDLE || decide) sc_q <= '0;
      else                                        sc_q <= sc_q + 1'b1;

      if (!enable_i || state_q == IDLE || decide) votes_q <= '0;
      else                                        votes_q <= votes_now;

      if (!enable_i || state_q == IDLE) bit_q <= '0;
      else if (shift_en)                bit_q <= last_bit ? '0 : bit_q + 1'b1;

      if (shift_en) shift_q[bit_q] <= bit_val;
      if (write)    hold_q         <= shift_q;

      full_q        <= write | (full_q & ~take_i);
      frame_error_q <= stop_bad;
      overrun_q     <= stop_good && full_q && !take_i;
    end
  end

  assign byte_o        = hold_q;
  assign full_o        = full_q;
  assign frame_error_o = frame_error_q;
  assign overrun_o     = overrun_q;

endmodule

// File: rtl/laser_rx_array.sv
// Multi-lane laser receiver: per-lane frame recovery plus an alignment stage
// presenting one byte from every lane as a wide valid/ready word.
module laser_rx_array
  import laser_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           laser_in,
  output logic [CHANNELS*DATA_BITS-1:0] data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [CHANNELS-1:0]           frame_error,
  output logic [CHANNELS-1:0]           overrun
);

  logic [CHANNELS-1:0]           full;
  logic [CHANNELS*DATA_BITS-1:0] hold_flat;
  logic [CHANNELS*DATA_BITS-1:0] data_q;
  logic                          valid_q;
  logic                          take;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    laser_rx_channel #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .enable_i     (enable),
      .laser_i      (laser_in[i]),
      .take_i       (take),
      .byte_o       (hold_flat[i*DATA_BITS +: DATA_BITS]),
      .full_o       (full[i]),
      .frame_error_o(frame_error[i]),
      .overrun_o    (overrun[i])
    );
  end

  // Transfer only a complete set, and only when the output slot is free or draining.
  assign take = (&full) && (!valid_q || data_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      data_q  <= hold_flat;
      valid_q <= 1'b1;
    end else if (data_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: doc/laser_rx_array.md
# laser_rx_array

Parametrised multi-channel laser link receiver, successor to the fixed two-channel 8-bit receiver. Each channel independently recovers start/data/stop frames from an oversampled laser photodiode input using a per-bit 3-sample majority vote, and rejects false starts and framing errors. Completed bytes from all channels are aligned in per-channel holding registers and presented as one wide word on a valid/ready interface toward the USB FIFO bridge.

## Interface
- `CHANNELS`, 2: number of laser lanes (1–8).
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `OVERSAMPLE`, 8: clock cycles per bit (≥4, even).
- `clock` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `enable` input, 1 bit: receiver enable; low aborts in-flight frames.
- `laser_in` input, `CHANNELS` bits: raw photodiode inputs, asynchronous. Idle level is 1.
- `data_out` output, `CHANNELS*DATA_BITS` bits: channel i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `data_valid` output, 1 bit: `data_out` holds an aligned word.
- `data_ready` input, 1 bit: consumer accepts the word when `data_valid & data_ready`.
- `frame_error` output, `CHANNELS` bits: one-cycle pulse when a frame is discarded for a stop bit of 0.
- `overrun` output, `CHANNELS` bits: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- **Input synchroniser.** Each `laser_in` bit passes through a 2-flop synchroniser. All logic uses the synchronised value `s`.
- **Channel FSM.** States IDLE, START, DATA, STOP. Each channel has a sample counter `sc` (0..OVERSAMPLE-1), a bit counter (0..DATA_BITS-1) and a 2-bit vote counter.
- **Vote.** The vote counter counts samples with `s=1` at `sc ∈ {M-1, M, M+1}`, where M = OVERSAMPLE/2. Bit value = (votes ≥ 2). The bit is decided at `sc = OVERSAMPLE-1`, and the vote counter clears in the same cycle.
- **IDLE → START** on `s=0` while `enable=1`. `sc` loads 0 in that cycle.
- **START end.** If the voted bit is 1 (false start), go to IDLE with no output. Otherwise go to DATA.
- **DATA.** The voted bit shifts into the shift register at position `bit_count` (LSB first). After DATA_BITS bits, go to STOP.
- **STOP end.** The FSM returns to IDLE in all cases.
  - Voted bit 0: pulse `frame_error[i]` and discard the frame.
  - Voted bit 1 and holding register empty: write the holding register and set `full[i]`.
  - Voted bit 1 and `full[i]` already set: pulse `overrun[i]`, drop the new byte and keep the old one.
- **Alignment.** When all `full[i]=1` and the output stage is empty or being accepted this cycle, all holding registers transfer to `data_out`, `data_valid` is set and all `full` flags clear.
  - If a channel's holding write coincides with its transfer, the write wins: `full` stays set with the new byte.
- **Handshake.** `data_valid` stays high and `data_out` stays stable until accepted. Acceptance with no pending transfer clears `data_valid`.
- **Enable low.** All channel FSMs go to IDLE and counters clear. Holding registers, `full` flags and the output stage are untouched.
- **Reset values.** All FSMs IDLE, counters 0, synchronisers 1, `full` 0, `data_out` 0, `data_valid` 0, `frame_error` 0, `overrun` 0.

## Timing
- The IDLE→START transition occurs 3 cycles after a falling edge on `laser_in`: 2 synchroniser cycles plus the detect cycle.
- The STOP decision occurs `(DATA_BITS+2)*OVERSAMPLE - 1` cycles after START entry.
- Stop decision at cycle T gives `full[i]=1` at T+1. `data_valid` rises at T+2 if this channel completed the set.
- A channel can accept a new start the cycle after its STOP decision, so frames may be back-to-back with no idle gap.
- The output stage sustains one word per clock under continuous `data_ready`. Throughput is bounded by frame length.
- Reset mid-frame aborts the frame with no error or overrun pulse.

## Structure
- **Package `laser_pkg`:**
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - Function `vote_window(sc, OVERSAMPLE)` returning the sample-enable.
  - Localparam for the synchroniser depth (2).
- **Sub-module `laser_rx_channel`.** Synchroniser, FSM, counters, shift register, `frame_error`/`overrun` generation, holding register and `full` flag.
  - Outputs a byte and a `full` flag; accepts a `take` strobe.
  - `laser_rx_array` instantiates it CHANNELS times and adds the alignment/output stage.

## Test plan
- **Clean frames.** CHANNELS=2, OVERSAMPLE=8: send 0xA5 on ch0 and 0x3C on ch1 simultaneously, `data_ready=1` → one `data_valid` pulse with `data_out=16'h3CA5` at the latency defined in Timing.
- **False start.** A 3-cycle low glitch on ch0 → returns to IDLE, no `data_valid`, no `frame_error`.
- **Framing error.** Stop bit forced 0 on ch1 with payload 0xFF → `frame_error=2'b10` for one cycle, no `data_valid`; the next good frame pair outputs normally.
- **Overrun.** ch0 receives 0x11 then 0x22 while ch1 stays idle → `overrun[0]` pulses on the second frame. After ch1 receives 0x99, `data_out=16'h9911`.
- **Backpressure.** Hold `data_ready=0` for 30 cycles after `data_valid` → `data_out` is stable throughout. Raising `data_ready` clears `data_valid` the next cycle, unless another aligned set is pending, in which case that set loads.
- **Noise and abort.** Single-cycle inverted samples at `sc=M` in every bit → bytes are still correct. Deasserting `enable` mid-frame and reasserting it → no output for the aborted frame, and the next frame is correct.
